// File: rtl/uart_proto_pkg.sv
// uart_proto_pkg
// Shared definitions for the UART bus-bridge protocol, host side.
// Protocol bytes always have bit 7 set. The lower 7 bits carry an ASCII command
// character or an uppercase hex digit.
// Contents: the channel characters, the protocol flag, the initiator FSM state
// type, and the hex digit encode/decode helpers.
package uart_proto_pkg;

  localparam logic [7:0] CH_ADDR    = 8'h41;  // 'A'
  localparam logic [7:0] CH_WRITE   = 8'h57;  // 'W'
  localparam logic [7:0] CH_READ    = 8'h52;  // 'R'
  localparam logic [7:0] PROTO_FLAG = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_GAP  = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [6:0] hex_enc(input logic [3:0] nib);
    logic [6:0] chr;
    if (nib < 4'd10) begin
      chr = 7'h30 + {3'b000, nib};
    end else begin
      chr = 7'h37 + {3'b000, nib};
    end
    return chr;
  endfunction

  // ASCII hex digit (either case) to {valid, nibble}. Non-hex input returns valid=0.
  function automatic logic [4:0] hex_dec(input logic [6:0] chr);
    logic [4:0] res;
    if ((chr >= 7'h30) && (chr <= 7'h39)) begin
      res = {1'b1, chr[3:0]};
    end else if ((chr >= 7'h41) && (chr <= 7'h46)) begin
      res = {1'b1, chr[3:0] + 4'd9};
    end else if ((chr >= 7'h61) && (chr <= 7'h66)) begin
      res = {1'b1, chr[3:0] + 4'd9};
    end else begin
      res = 5'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_frame_builder.sv
// uart_frame_builder
// Combinational selector that returns one byte of a request frame.
// The frame is chosen by the captured request and the byte index:
//   write: 'A' a3 a2 a1 a0 'W' d1 d0   (8 bytes)
//   read : 'A' a3 a2 a1 a0 'R'         (6 bytes)
// Every byte has the protocol flag (bit 7) set.
// Ports:
//   we         in   1=write frame, 0=read frame
//   addr       in   16-bit bus address
//   dat        in   8-bit write data
//   idx        in   byte position within the frame
//   frame_byte out  byte to transmit at position idx
//   frame_len  out  number of bytes in the frame (8 or 6)
module uart_frame_builder
  import uart_proto_pkg::*;
(
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  dat,
  input  logic [2:0]  idx,
  output logic [7:0]  frame_byte,
  output logic [3:0]  frame_len
);

  // Pick the protocol character for the current byte position.
  always_comb begin
    frame_byte = PROTO_FLAG;
    case (idx)
      3'd0: frame_byte = PROTO_FLAG | CH_ADDR;
      3'd1: frame_byte = PROTO_FLAG | {1'b0, hex_enc(addr[15:12])};
      3'd2: frame_byte = PROTO_FLAG | {1'b0, hex_enc(addr[11:8])};
      3'd3: frame_byte = PROTO_FLAG | {1'b0, hex_enc(addr[7:4])};
      3'd4: frame_byte = PROTO_FLAG | {1'b0, hex_enc(addr[3:0])};
      3'd5: begin
        if (we) begin
          frame_byte = PROTO_FLAG | CH_WRITE;
        end else begin
          frame_byte = PROTO_FLAG | CH_READ;
        end
      end
      3'd6: frame_byte = PROTO_FLAG | {1'b0, hex_enc(dat[7:4])};
      3'd7: frame_byte = PROTO_FLAG | {1'b0, hex_enc(dat[3:0])};
      default: frame_byte = PROTO_FLAG;
    endcase
  end

  assign frame_len = we ? 4'd8 : 4'd6;

endmodule

// File: rtl/uart_bus_initiator.sv
// uart_bus_initiator
// Host-side initiator for the UART bus-bridge protocol. It serialises one bus
// request into a protocol frame on a uart_tx byte interface. For a read, it then
// decodes the two-digit hex reply that arrives on a uart_rx byte interface.
// Received bytes with bit 7 clear belong to the data channel and are ignored.
// Ports:
//   i_clk, i_reset          clock; asynchronous active-high reset
//   i_req/i_we/i_addr/i_dat request, captured only while idle
//   o_dat                   read data, held until the next read completes
//   o_ack/o_err             one-cycle completion pulse and its error qualifier
//   o_busy                  transaction in progress, up to and including o_ack
//   o_tx_dat/o_tx_start     byte and start strobe to uart_tx
//   i_tx_ready              uart_tx is idle
//   i_rx_dat/i_rx_pulse     received byte and its one-cycle valid strobe
module uart_bus_initiator
  import uart_proto_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_dat,
  output logic [7:0]  o_dat,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_busy,
  output logic [7:0]  o_tx_dat,
  output logic        o_tx_start,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_rx_dat,
  input  logic        i_rx_pulse
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_r, state_s;
  logic [2:0]       idx_r, idx_s;
  logic             we_r, we_s;
  logic [15:0]      addr_r, addr_s;
  logic [7:0]       dat_r, dat_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             hi_valid_r, hi_valid_s;
  logic [3:0]       hi_nib_r, hi_nib_s;
  logic [7:0]       rd_dat_r, rd_dat_s;
  logic [7:0]       tx_dat_r, tx_dat_s;
  logic             tx_start_r, tx_start_s;
  logic             ack_r, ack_s;
  logic             err_r, err_s;
  logic             busy_r, busy_s;
  logic [4:0]       rx_nib_s;
  logic [7:0]       frame_byte_s;
  logic [3:0]       frame_len_s;

  uart_frame_builder u_frame (
    .we         (we_r),
    .addr       (addr_r),
    .dat        (dat_r),
    .idx        (idx_r),
    .frame_byte (frame_byte_s),
    .frame_len  (frame_len_s)
  );

  // Next-state and next-output logic.
  // Outputs are computed for the coming cycle, so that o_ack lines up with DONE.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    we_s       = we_r;
    addr_s     = addr_r;
    dat_s      = dat_r;
    cnt_s      = cnt_r;
    hi_valid_s = hi_valid_r;
    hi_nib_s   = hi_nib_r;
    rd_dat_s   = rd_dat_r;
    tx_dat_s   = tx_dat_r;
    tx_start_s = 1'b0;
    ack_s      = 1'b0;
    err_s      = 1'b0;
    rx_nib_s   = hex_dec(i_rx_dat[6:0]);
    case (state_r)
      ST_IDLE: begin
        if (i_req) begin
          we_s    = i_we;
          addr_s  = i_addr;
          dat_s   = i_dat;
          idx_s   = 3'd0;
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          tx_start_s = 1'b1;
          tx_dat_s   = frame_byte_s;
          state_s    = ST_GAP;
        end else begin
          state_s = ST_SEND;
        end
      end
      // The one-cycle gap lets uart_tx drop i_tx_ready before SEND samples it again.
      ST_GAP: begin
        idx_s = idx_r + 3'd1;
        if (({1'b0, idx_r} + 4'd1) == frame_len_s) begin
          if (we_r) begin
            state_s = ST_DONE;
            ack_s   = 1'b1;
          end else begin
            state_s    = ST_RESP;
            cnt_s      = CNT_ZERO;
            hi_valid_s = 1'b0;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_RESP: begin
        if (i_rx_pulse && i_rx_dat[7]) begin
          cnt_s = CNT_ZERO;
          if (!rx_nib_s[4]) begin
            state_s = ST_DONE;
            ack_s   = 1'b1;
            err_s   = 1'b1;
          end else if (!hi_valid_r) begin
            hi_valid_s = 1'b1;
            hi_nib_s   = rx_nib_s[3:0];
          end else begin
            rd_dat_s = {hi_nib_r, rx_nib_s[3:0]};
            state_s  = ST_DONE;
            ack_s    = 1'b1;
          end
        end else if (cnt_r == CNT_LAST) begin
          state_s  = ST_DONE;
          ack_s    = 1'b1;
          err_s    = 1'b1;
          rd_dat_s = 8'h00;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers.
  // A reset aborts any transaction immediately, without an acknowledge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= 3'd0;
      we_r       <= 1'b0;
      addr_r     <= 16'h0000;
      dat_r      <= 8'h00;
      cnt_r      <= CNT_ZERO;
      hi_valid_r <= 1'b0;
      hi_nib_r   <= 4'h0;
      rd_dat_r   <= 8'h00;
      tx_dat_r   <= 8'h00;
      tx_start_r <= 1'b0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      we_r       <= we_s;
      addr_r     <= addr_s;
      dat_r      <= dat_s;
      cnt_r      <= cnt_s;
      hi_valid_r <= hi_valid_s;
      hi_nib_r   <= hi_nib_s;
      rd_dat_r   <= rd_dat_s;
      tx_dat_r   <= tx_dat_s;
      tx_start_r <= tx_start_s;
      ack_r      <= ack_s;
      err_r      <= err_s;
      busy_r     <= busy_s;
    end
  end

  assign o_dat      = rd_dat_r;
  assign o_ack      = ack_r;
  assign o_err      = err_r;
  assign o_busy     = busy_r;
  assign o_tx_dat   = tx_dat_r;
  assign o_tx_start = tx_start_r;

endmodule

// File: tb/tb_uart_bus_initiator.sv
// tb_uart_bus_initiator
// Self-checking bench for uart_bus_initiator, run with TIMEOUT_CYCLES=100.
// A uart_tx model drops ready for a few cycles after each start. A scoreboard
// holds the expected frame bytes and completions, and they are compared as
// the DUT produces them.
module tb_uart_bus_initiator;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic [7:0]  i_dat = 8'h00;
  logic [7:0]  o_dat;
  logic        o_ack;
  logic        o_err;
  logic        o_busy;
  logic [7:0]  o_tx_dat;
  logic        o_tx_start;
  logic        i_tx_ready = 1'b1;
  logic [7:0]  i_rx_dat = 8'h00;
  logic        i_rx_pulse = 1'b0;

  typedef struct packed {
    logic       err;
    logic [7:0] dat;
    logic       chk_dat;
  } exp_ack_t;

  logic [7:0] exp_tx_q [$];
  exp_ack_t   exp_ack_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tx_seen = 0;
  int ack_cnt = 0;
  int tx_busy = 0;
  int last_start_cyc = 0;
  int last_ack_cyc = 0;
  logic [7:0] model_dat = 8'h00;
  string hx = "0123456789ABCDEF";

  uart_bus_initiator #(.TIMEOUT_CYCLES(100)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_addr     (i_addr),
    .i_dat      (i_dat),
    .o_dat      (o_dat),
    .o_ack      (o_ack),
    .o_err      (o_err),
    .o_busy     (o_busy),
    .o_tx_dat   (o_tx_dat),
    .o_tx_start (o_tx_start),
    .i_tx_ready (i_tx_ready),
    .i_rx_dat   (i_rx_dat),
    .i_rx_pulse (i_rx_pulse)
  );

  always #5 i_clk = ~i_clk;

  // Cycle counter for latency measurements.
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] nib);
    return hx[nib] | 8'h80;
  endfunction

  task automatic push_frame(input logic we, input logic [15:0] addr, input logic [7:0] dat);
    exp_tx_q.push_back(8'hC1);
    exp_tx_q.push_back(asc(addr[15:12]));
    exp_tx_q.push_back(asc(addr[11:8]));
    exp_tx_q.push_back(asc(addr[7:4]));
    exp_tx_q.push_back(asc(addr[3:0]));
    if (we) begin
      exp_tx_q.push_back(8'hD7);
      exp_tx_q.push_back(asc(dat[7:4]));
      exp_tx_q.push_back(asc(dat[3:0]));
    end else begin
      exp_tx_q.push_back(8'hD2);
    end
  endtask

  task automatic push_ack(input logic err, input logic [7:0] dat, input logic chk_dat);
    exp_ack_t e;
    e.err = err;
    e.dat = dat;
    e.chk_dat = chk_dat;
    exp_ack_q.push_back(e);
  endtask

  // uart_tx model, scoreboard compare for tx bytes and completions.
  always @(negedge i_clk) begin
    if (o_tx_start && !i_reset) begin
      tx_seen++;
      last_start_cyc = cyc;
      chk("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
      if (exp_tx_q.size() != 0) chk("tx_byte", 32'(o_tx_dat), 32'(exp_tx_q.pop_front()));
      i_tx_ready = 1'b0;
      tx_busy = 6;
    end else if (tx_busy > 0) begin
      tx_busy--;
      if (tx_busy == 0) i_tx_ready = 1'b1;
    end
    if (o_ack && !i_reset) begin
      exp_ack_t e;
      ack_cnt++;
      last_ack_cyc = cyc;
      chk("busy_at_ack", 32'(o_busy), 32'd1);
      chk("ack_expected", 32'(exp_ack_q.size() != 0), 32'd1);
      if (exp_ack_q.size() != 0) begin
        e = exp_ack_q.pop_front();
        chk("ack_err", 32'(o_err), 32'(e.err));
        if (e.chk_dat) chk("ack_dat", 32'(o_dat), 32'(e.dat));
      end
    end
  end

  task automatic wait_ack(input int start_cnt, input string tag);
    int n = 0;
    while (ack_cnt == start_cnt && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_ack_seen"}, 32'(ack_cnt != start_cnt), 32'd1);
  endtask

  task automatic start_txn(input logic we, input logic [15:0] addr, input logic [7:0] dat);
    int n = 0;
    while (o_busy && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    push_frame(we, addr, dat);
    @(negedge i_clk);
    i_we = we;
    i_addr = addr;
    i_dat = dat;
    i_req = 1'b1;
    @(negedge i_clk);
    i_req = 1'b0;
    i_we = ~we;
    i_addr = ~addr;
    i_dat = ~dat;
  endtask

  task automatic send_rx(input logic [7:0] b);
    i_rx_dat = b;
    i_rx_pulse = 1'b1;
    @(negedge i_clk);
    i_rx_pulse = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] dat);
    int a0 = ack_cnt;
    push_ack(1'b0, model_dat, 1'b1);
    start_txn(1'b1, addr, dat);
    wait_ack(a0, "wr");
  endtask

  task automatic do_read(input logic [15:0] addr, input int nr, input logic [7:0] r0,
                         input logic [7:0] r1, input logic [7:0] r2, input logic e_err,
                         input logic [7:0] e_dat, input logic e_chk);
    int a0 = ack_cnt;
    int n = 0;
    push_ack(e_err, e_dat, e_chk);
    start_txn(1'b0, addr, 8'h00);
    while (exp_tx_q.size() != 0 && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    repeat (3) @(negedge i_clk);
    for (int i = 0; i < nr; i++) begin
      send_rx((i == 0) ? r0 : ((i == 1) ? r1 : r2));
      repeat (2) @(negedge i_clk);
    end
    wait_ack(a0, "rd");
    if (e_chk) model_dat = e_dat;
  endtask

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int t0;
    repeat (3) @(negedge i_clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_tx", 32'({o_tx_start, o_tx_dat, o_dat, o_err}), 32'd0);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Test 1: write frame with the literal expected bytes, and protocol rx ignored.
    a0 = ack_cnt;
    push_ack(1'b0, model_dat, 1'b1);
    exp_tx_q.push_back(8'hC1); exp_tx_q.push_back(8'hB1); exp_tx_q.push_back(8'hB2);
    exp_tx_q.push_back(8'hC1); exp_tx_q.push_back(8'hC2); exp_tx_q.push_back(8'hD7);
    exp_tx_q.push_back(8'hB5); exp_tx_q.push_back(8'hC3);
    @(negedge i_clk);
    i_we = 1'b1; i_addr = 16'h12AB; i_dat = 8'h5C; i_req = 1'b1;
    @(negedge i_clk);
    i_req = 1'b0; i_addr = 16'h0000; i_dat = 8'h00;
    repeat (10) @(negedge i_clk);
    send_rx(8'hB7);
    send_rx(8'hC1);
    wait_ack(a0, "t1");

    // Test 2/3: reads with upper- and lowercase replies and an ignored data-channel byte.
    do_read(16'h0010, 2, 8'hB3, 8'hC6, 8'h00, 1'b0, 8'h3F, 1'b1);
    do_read(16'hA5F0, 2, 8'hB5, 8'hC1, 8'h00, 1'b0, 8'h5A, 1'b1);
    do_read(16'h0010, 2, 8'hB3, 8'hE6, 8'h00, 1'b0, 8'h3F, 1'b1);
    do_read(16'hFFFF, 2, 8'hB7, 8'hC4, 8'h00, 1'b0, 8'h7D, 1'b1);
    do_read(16'h0123, 3, 8'hB3, 8'h41, 8'hC6, 1'b0, 8'h3F, 1'b1);

    // Test 4: timeout, then malformed reply, then recovery.
    do_read(16'h4000, 0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1);
    // Start shows in the GAP cycle; 100 RESP cycles follow, then DONE.
    chk("timeout_delay", 32'(last_ack_cyc - last_start_cyc), 32'd101);
    do_read(16'h4001, 2, 8'hB3, 8'hD8, 8'h00, 1'b1, 8'h00, 1'b0);
    do_read(16'h4002, 2, 8'hB3, 8'hC6, 8'h00, 1'b0, 8'h3F, 1'b1);

    // Test 5: extra requests while busy are ignored.
    a0 = ack_cnt;
    t0 = tx_seen;
    push_ack(1'b0, model_dat, 1'b1);
    start_txn(1'b1, 16'hBEEF, 8'h01);
    repeat (10) @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b0; i_addr = 16'h1111;
    @(negedge i_clk);
    i_req = 1'b0;
    repeat (20) @(negedge i_clk);
    i_req = 1'b1;
    @(negedge i_clk);
    i_req = 1'b0;
    wait_ack(a0, "t5");
    repeat (150) @(negedge i_clk);
    chk("t5_acks", 32'(ack_cnt - a0), 32'd1);
    chk("t5_bytes", 32'(tx_seen - t0), 32'd8);

    // Test 6: asynchronous reset after the third byte of a write.
    a0 = ack_cnt;
    t0 = tx_seen;
    push_ack(1'b0, model_dat, 1'b1);
    start_txn(1'b1, 16'hC0DE, 8'hA7);
    for (int n = 0; n < 3000 && tx_seen < t0 + 3; n++) @(negedge i_clk);
    chk("t6_three_bytes", 32'(tx_seen - t0), 32'd3);
    #2;
    i_reset = 1'b1;
    #1;
    chk("t6_busy", 32'(o_busy), 32'd0);
    chk("t6_outs", 32'({o_tx_start, o_tx_dat, o_ack, o_err}), 32'd0);
    chk("t6_dat", 32'(o_dat), 32'd0);
    exp_tx_q.delete();
    exp_ack_q.delete();
    model_dat = 8'h00;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (20) @(negedge i_clk);
    chk("t6_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("t6_idle", 32'(o_busy), 32'd0);
    do_write(16'h9876, 8'h3E);

    repeat (20) @(negedge i_clk);
    chk("tx_q_empty", 32'(exp_tx_q.size()), 32'd0);
    chk("ack_q_empty", 32'(exp_ack_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
